// File: rtl/eth_pkt_mon.sv
`default_nettype none
// ============================================================================
// Module   : eth_pkt_mon
// Brief    : Per-port packet framing monitor (length, XOR signature, counts,
//            framing errors). Optional length check: ETH_PKT_MON_LEN_CHK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module eth_pkt_mon #(
    parameter int NUM_PORTS = 2,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 16,
    parameter int CNT_W     = 32,
    parameter int MIN_WORDS = 2,
    parameter int MAX_WORDS = 384
) (
    input  logic                        clk,
    input  logic                        resetN,
    input  logic                        clr,
    input  logic [NUM_PORTS*DATA_W-1:0] data,
    input  logic [NUM_PORTS-1:0]        sop,
    input  logic [NUM_PORTS-1:0]        eop,
    input  logic [NUM_PORTS-1:0]        stall,
    output logic [NUM_PORTS-1:0]        done,
    output logic [NUM_PORTS*LEN_W-1:0]  len,
    output logic [NUM_PORTS*DATA_W-1:0] sig,
    output logic [NUM_PORTS-1:0]        err,
    output logic [NUM_PORTS*2-1:0]      err_code,
    output logic [NUM_PORTS*CNT_W-1:0]  pkt_cnt,
    output logic [NUM_PORTS*CNT_W-1:0]  err_cnt
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } state_t;

    localparam logic [1:0] c_EOP_NO_SOP = 2'b01;
    localparam logic [1:0] c_SOP_IN_PKT = 2'b10;
    localparam logic [1:0] c_LEN_VIOL   = 2'b11;

`ifndef ETH_PKT_MON_LEN_CHK_EN
    logic [63:0] w_unusedLenParams;
    assign w_unusedLenParams = {32'(MIN_WORDS), 32'(MAX_WORDS)};
`endif

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        logic [DATA_W-1:0] w_data;
        state_t            r_state;
        state_t            w_nextState;
        logic [LEN_W-1:0]  r_accLen;
        logic [LEN_W-1:0]  w_accLen;
        logic [LEN_W-1:0]  w_lenInc;
        logic [LEN_W-1:0]  w_finLen;
        logic [DATA_W-1:0] r_accSig;
        logic [DATA_W-1:0] w_accSig;
        logic [DATA_W-1:0] w_finSig;
        logic              w_done;
        logic              w_err;
        logic [1:0]        w_code;
        logic              r_done;
        logic              r_err;
        logic [1:0]        r_errCode;
        logic [LEN_W-1:0]  r_len;
        logic [DATA_W-1:0] r_sig;
        logic [CNT_W-1:0]  r_pktCnt;
        logic [CNT_W-1:0]  r_errCnt;

        assign w_data   = data[gi*DATA_W +: DATA_W];
        assign w_lenInc = (r_accLen == {LEN_W{1'b1}}) ? r_accLen : r_accLen + LEN_W'(1);

        always_comb begin
            w_nextState = r_state;
            w_accLen    = r_accLen;
            w_accSig    = r_accSig;
            w_finLen    = r_accLen;
            w_finSig    = r_accSig;
            w_done      = 1'b0;
            w_err       = 1'b0;
            w_code      = r_errCode;
            if (!stall[gi]) begin
                case (r_state)
                    IDLE: begin
                        if (sop[gi]) begin
                            w_accLen = LEN_W'(1);
                            w_accSig = w_data;
                            if (eop[gi]) begin
                                w_done   = 1'b1;
                                w_finLen = LEN_W'(1);
                                w_finSig = w_data;
                            end else begin
                                w_nextState = IN_PKT;
                            end
                        end else if (eop[gi]) begin
                            w_err  = 1'b1;
                            w_code = c_EOP_NO_SOP;
                        end
                    end
                    IN_PKT: begin
                        if (sop[gi]) begin
                            // Abandon the open packet and restart from this word
                            w_err    = 1'b1;
                            w_code   = c_SOP_IN_PKT;
                            w_accLen = LEN_W'(1);
                            w_accSig = w_data;
                            if (eop[gi]) begin
                                w_done      = 1'b1;
                                w_finLen    = LEN_W'(1);
                                w_finSig    = w_data;
                                w_nextState = IDLE;
                            end
                        end else begin
                            w_accLen = w_lenInc;
                            w_accSig = r_accSig ^ w_data;
                            if (eop[gi]) begin
                                w_done      = 1'b1;
                                w_finLen    = w_lenInc;
                                w_finSig    = r_accSig ^ w_data;
                                w_nextState = IDLE;
                            end
                        end
                    end
                    default: w_nextState = IDLE;
                endcase
`ifdef ETH_PKT_MON_LEN_CHK_EN
                if (w_done && !w_err &&
                    ((w_finLen < LEN_W'(MIN_WORDS)) || (w_finLen > LEN_W'(MAX_WORDS)))) begin
                    w_err  = 1'b1;
                    w_code = c_LEN_VIOL;
                end
`endif
            end
        end

        always_ff @(posedge clk or negedge resetN) begin
            if (!resetN) begin
                r_state   <= IDLE;
                r_accLen  <= '0;
                r_accSig  <= '0;
                r_done    <= 1'b0;
                r_err     <= 1'b0;
                r_errCode <= 2'b00;
                r_len     <= '0;
                r_sig     <= '0;
                r_pktCnt  <= '0;
                r_errCnt  <= '0;
            end else begin
                r_state  <= w_nextState;
                r_accLen <= w_accLen;
                r_accSig <= w_accSig;
                r_done   <= w_done;
                r_err    <= w_err;
                if (w_done) begin
                    r_len <= w_finLen;
                    r_sig <= w_finSig;
                end
                if (w_err) begin
                    r_errCode <= w_code;
                end
                // Clear wins over a same-cycle increment
                if (clr) begin
                    r_pktCnt <= '0;
                    r_errCnt <= '0;
                end else begin
                    if (w_done) r_pktCnt <= r_pktCnt + CNT_W'(1);
                    if (w_err)  r_errCnt <= r_errCnt + CNT_W'(1);
                end
            end
        end

        assign done[gi]                    = r_done;
        assign err[gi]                     = r_err;
        assign err_code[gi*2 +: 2]         = r_errCode;
        assign len[gi*LEN_W +: LEN_W]      = r_len;
        assign sig[gi*DATA_W +: DATA_W]    = r_sig;
        assign pkt_cnt[gi*CNT_W +: CNT_W]  = r_pktCnt;
        assign err_cnt[gi*CNT_W +: CNT_W]  = r_errCnt;
    end

endmodule
`default_nettype wire

// File: tb/tb_eth_pkt_mon.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_pkt_mon
// Brief    : Self-checking bench for eth_pkt_mon: queue-based packet model,
//            per-cycle compare, plus directed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_pkt_mon;

    localparam int NP   = 2;
    localparam int DW   = 32;
    localparam int LW   = 16;
    localparam int CW   = 32;
    localparam int MINW = 2;
    localparam int MAXW = 384;

    logic              clk = 1'b0;
    logic              resetN;
    logic              clr;
    logic [NP*DW-1:0]  data;
    logic [NP-1:0]     sop, eop, stall;
    logic [NP-1:0]     done, err;
    logic [NP*LW-1:0]  len;
    logic [NP*DW-1:0]  sig;
    logic [NP*2-1:0]   err_code;
    logic [NP*CW-1:0]  pkt_cnt, err_cnt;

    int checks = 0;
    int errors = 0;

    eth_pkt_mon #(
        .NUM_PORTS(NP), .DATA_W(DW), .LEN_W(LW), .CNT_W(CW),
        .MIN_WORDS(MINW), .MAX_WORDS(MAXW)
    ) dut (
        .clk(clk), .resetN(resetN), .clr(clr), .data(data),
        .sop(sop), .eop(eop), .stall(stall),
        .done(done), .len(len), .sig(sig), .err(err), .err_code(err_code),
        .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Packet model: open packet kept as a queue of words
    // ------------------------------------------------------------------
    logic [DW-1:0] mq [NP][$];
    bit            inPkt  [NP];
    logic          expDone[NP];
    logic          expErr [NP];
    logic [1:0]    expCode[NP];
    logic [LW-1:0] expLen [NP];
    logic [DW-1:0] expSig [NP];
    logic [CW-1:0] expPkt [NP];
    logic [CW-1:0] expErrC[NP];
    logic [DW-1:0] mWord;
    logic [DW-1:0] mSig;
    int            mN;
    bit            mDone, mErr;
    logic [1:0]    mCode;

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int p = 0; p < NP; p++) begin
                inPkt[p] = 0;
                mq[p].delete();
                expDone[p] = 0; expErr[p] = 0; expCode[p] = 0;
                expLen[p] = 0; expSig[p] = 0; expPkt[p] = 0; expErrC[p] = 0;
            end
        end else begin
            for (int p = 0; p < NP; p++) begin
                mDone = 0; mErr = 0; mCode = 0;
                if (!stall[p]) begin
                    mWord = data[p*DW +: DW];
                    if (sop[p]) begin
                        if (inPkt[p]) begin mErr = 1; mCode = 2'b10; end
                        mq[p].delete();
                        mq[p].push_back(mWord);
                        inPkt[p] = 1;
                    end else if (inPkt[p]) begin
                        mq[p].push_back(mWord);
                    end else if (eop[p]) begin
                        mErr = 1; mCode = 2'b01;
                    end
                    if (eop[p] && inPkt[p]) begin
                        mDone = 1;
                        mN = mq[p].size();
                        mSig = '0;
                        for (int k = 0; k < mN; k++) mSig ^= mq[p][k];
                        expLen[p] = (mN > (1 << LW) - 1) ? LW'((1 << LW) - 1) : LW'(mN);
                        expSig[p] = mSig;
                        inPkt[p] = 0;
                        mq[p].delete();
`ifdef ETH_PKT_MON_LEN_CHK_EN
                        if (!mErr && (mN < MINW || mN > MAXW)) begin
                            mErr = 1; mCode = 2'b11;
                        end
`endif
                    end
                end
                expDone[p] = mDone;
                expErr[p]  = mErr;
                if (mErr) expCode[p] = mCode;
                if (clr) begin
                    expPkt[p] = 0; expErrC[p] = 0;
                end else begin
                    if (mDone) expPkt[p] = expPkt[p] + 1;
                    if (mErr)  expErrC[p] = expErrC[p] + 1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle compare of every output against the model
    // ------------------------------------------------------------------
    task automatic cmp(input string name, input int p, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s port%0d t=%0t actual=%0h required=%0h", name, p, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int p = 0; p < NP; p++) begin
            cmp("done",    p, 64'(done[p]),              64'(expDone[p]));
            cmp("err",     p, 64'(err[p]),               64'(expErr[p]));
            cmp("err_code",p, 64'(err_code[p*2 +: 2]),   64'(expCode[p]));
            cmp("len",     p, 64'(len[p*LW +: LW]),      64'(expLen[p]));
            cmp("sig",     p, 64'(sig[p*DW +: DW]),      64'(expSig[p]));
            cmp("pkt_cnt", p, 64'(pkt_cnt[p*CW +: CW]),  64'(expPkt[p]));
            cmp("err_cnt", p, 64'(err_cnt[p*CW +: CW]),  64'(expErrC[p]));
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------
    task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL lit_%s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    task automatic cyc(input logic [NP-1:0] s, input logic [NP-1:0] e, input logic [NP-1:0] st,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic c);
        sop = s; eop = e; stall = st; data = {d1, d0}; clr = c;
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        cyc(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        resetN = 1'b0; clr = 0; sop = 0; eop = 0; stall = 0; data = '0;
        repeat (3) @(posedge clk);
        #2;
        lit("rst_done", 64'(done), 64'h0);
        lit("rst_pktcnt", 64'(pkt_cnt), 64'h0);
        resetN = 1'b1;
        idle();

        // 4-word packet on port 0
        cyc(2'b01, 2'b00, 2'b00, 32'h1, 32'h0, 0);
        cyc(2'b00, 2'b00, 2'b00, 32'h2, 32'h0, 0);
        cyc(2'b00, 2'b00, 2'b00, 32'h3, 32'h0, 0);
        cyc(2'b00, 2'b01, 2'b00, 32'h4, 32'h0, 0);
        lit("p0_done", 64'(done[0]), 64'h1);
        lit("p0_len", 64'(len[15:0]), 64'h4);
        lit("p0_sig", 64'(sig[31:0]), 64'h4);
        lit("p0_pktcnt", 64'(pkt_cnt[31:0]), 64'h1);
        lit("p0_err", 64'(err[0]), 64'h0);
        lit("model_len", 64'(expLen[0]), 64'h4);

        // Single-word packet on port 1
        cyc(2'b10, 2'b10, 2'b00, 32'h0, 32'hA5A5A5A5, 0);
        lit("p1_done", 64'(done[1]), 64'h1);
        lit("p1_len", 64'(len[31:16]), 64'h1);
        lit("p1_sig", 64'(sig[63:32]), 64'hA5A5A5A5);
        lit("p0_len_hold", 64'(len[15:0]), 64'h4);
        lit("p0_done_low", 64'(done[0]), 64'h0);
        idle();

        // EOP while idle, then SOP inside a packet
        cyc(2'b00, 2'b01, 2'b00, 32'h9, 32'h0, 0);
        lit("eopnosop_err", 64'(err[0]), 64'h1);
        lit("eopnosop_code", 64'(err_code[1:0]), 64'h1);
        lit("eopnosop_errcnt", 64'(err_cnt[31:0]), 64'h1);
        lit("eopnosop_pktcnt", 64'(pkt_cnt[31:0]), 64'h1);
        cyc(2'b01, 2'b00, 2'b00, 32'h5, 32'h0, 0);
        cyc(2'b00, 2'b00, 2'b00, 32'h6, 32'h0, 0);
        cyc(2'b01, 2'b00, 2'b00, 32'h7, 32'h0, 0);
        lit("sopin_err", 64'(err[0]), 64'h1);
        lit("sopin_code", 64'(err_code[1:0]), 64'h2);
        lit("sopin_nodone", 64'(done[0]), 64'h0);
        cyc(2'b00, 2'b01, 2'b00, 32'h8, 32'h0, 0);
        lit("restart_len", 64'(len[15:0]), 64'h2);
        lit("restart_sig", 64'(sig[31:0]), 64'hF);
        lit("restart_pktcnt", 64'(pkt_cnt[31:0]), 64'h2);

        // Stalled cycles with garbage in the middle of a packet
        cyc(2'b01, 2'b00, 2'b00, 32'h10, 32'h0, 0);
        cyc(2'b01, 2'b01, 2'b01, 32'hDEADBEEF, 32'h0, 0);
        cyc(2'b01, 2'b01, 2'b01, 32'h12345678, 32'h0, 0);
        cyc(2'b00, 2'b01, 2'b01, 32'hFFFF0000, 32'h0, 0);
        cyc(2'b00, 2'b00, 2'b00, 32'h20, 32'h0, 0);
        cyc(2'b00, 2'b00, 2'b00, 32'h30, 32'h0, 0);
        cyc(2'b00, 2'b01, 2'b00, 32'h40, 32'h0, 0);
        lit("stall_len", 64'(len[15:0]), 64'h4);
        lit("stall_sig", 64'(sig[31:0]), 64'h40);
        idle();

        // Reset mid-packet
        cyc(2'b01, 2'b00, 2'b00, 32'h1, 32'h0, 0);
        cyc(2'b00, 2'b00, 2'b00, 32'h2, 32'h0, 0);
        resetN = 1'b0;
        sop = 0; eop = 0;
        @(posedge clk); #2;
        lit("rstmid_len", 64'(len[15:0]), 64'h0);
        resetN = 1'b1;
        cyc(2'b00, 2'b01, 2'b00, 32'h3, 32'h0, 0);
        lit("rstmid_nodone", 64'(done[0]), 64'h0);
        lit("rstmid_code", 64'(err_code[1:0]), 64'h1);

        // Clear, including a dropped same-cycle increment
        cyc(2'b01, 2'b00, 2'b00, 32'h1, 32'h0, 0);
        cyc(2'b00, 2'b01, 2'b00, 32'h2, 32'h0, 1);
        lit("clr_done", 64'(done[0]), 64'h1);
        lit("clr_pktcnt", 64'(pkt_cnt[31:0]), 64'h0);
        lit("clr_errcnt", 64'(err_cnt[31:0]), 64'h0);

        // Single-word packet: length violation only when the check is built in
        cyc(2'b01, 2'b01, 2'b00, 32'h55, 32'h0, 0);
        lit("short_done", 64'(done[0]), 64'h1);
`ifdef ETH_PKT_MON_LEN_CHK_EN
        lit("short_err", 64'(err[0]), 64'h1);
        lit("short_code", 64'(err_code[1:0]), 64'h3);
        lit("short_errcnt", 64'(err_cnt[31:0]), 64'h1);
`else
        lit("short_noerr", 64'(err[0]), 64'h0);
        lit("short_errcnt", 64'(err_cnt[31:0]), 64'h0);
`endif
        lit("short_pktcnt", 64'(pkt_cnt[31:0]), 64'h1);

        // Pseudo-random traffic on both ports, checked by the model only
        for (int i = 0; i < 400; i++) begin
            cyc({($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0)},
                {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)},
                {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)},
                $urandom, $urandom, ($urandom_range(0, 39) == 0));
        end
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
